input_fifo: RTL
===============

# input_fifo

Per-input-port flit buffer that sits directly upstream of the LBDR routing stage. It accepts flits from the link and stores up to DEPTH of them. It presents the head flit's `empty`, `flit_id` and `dst_addr` to LBDR, and returns one credit upstream for every flit drained. A write-side packet-framing FSM checks HEADER/PAYLOAD/TAIL ordering and flags protocol violations.

## Interface
- `DATA_WIDTH`, 32, flit width; `[31:29]` is flit_id, `[3:0]` is dst_addr (valid on HEADER flits only).
- `DEPTH`, 4, number of flit slots; must be a power of two, ≥2.
- `PTR_W`, `$clog2(DEPTH)`, pointer width (derived; not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  link presents a flit this cycle.
- `data_in`  in  DATA_WIDTH  incoming flit.
- `read_en`  in  1  downstream (allocator/crossbar) consumes the head flit this cycle.
- `data_out`  out  DATA_WIDTH  head flit (fall-through view of `mem[rd_ptr]`).
- `flit_id`  out  3  `data_out[31:29]`.
- `dst_addr`  out  4  `data_out[3:0]`.
- `empty`  out  1  no flit stored.
- `full`  out  1  DEPTH flits stored.
- `credit_out`  out  1  one-cycle pulse, registered, per flit drained.
- `err_overflow`  out  1  sticky: write attempted while full.
- `err_framing`  out  1  sticky: illegal flit_id sequence on the write side.

## Operation
- Storage: circular buffer `mem[DEPTH]`, `rd_ptr`/`wr_ptr` of PTR_W bits, and an occupancy `count` of PTR_W+1 bits. Pointers wrap modulo DEPTH.
- Write accepted when `valid_in & ~full`. The flit goes to `mem[wr_ptr]` and `wr_ptr` increments.
- Read accepted when `read_en & ~empty`. `rd_ptr` increments, and `credit_out` is 1 on the next cycle.
- `read_en` while empty is ignored: no pointer move, no credit.
- Write while full: the flit is dropped, `err_overflow` is set, and `wr_ptr`/`count` are unchanged. `full` is evaluated on the pre-cycle state, so a simultaneous read does not make room for the write that cycle.
- Simultaneous accepted read and write: `count` is unchanged and both pointers advance.
- Write into an empty FIFO: the data is visible on `data_out` the following cycle. A write never bypasses directly to the output.
- `empty = (count==0)`, `full = (count==DEPTH)`, both decoded combinationally from `count`.
- Framing FSM, advanced on accepted writes only:
  - IDLE: HEADER → IN_PKT. PAYLOAD or TAIL → set `err_framing`, stay IDLE.
  - IN_PKT: PAYLOAD → stay IN_PKT. TAIL → IDLE. HEADER → set `err_framing`, stay IN_PKT.
  - Any undefined flit_id code in either state → set `err_framing`, state unchanged.
- Erroneous flits are still stored. Error flags only report; they never block writes.
- Flit codes `HEADER=3'b001`, `PAYLOAD=3'b010`, `TAIL=3'b100` are taken from the shared parameter definitions.

## Timing
- Reset, when `rst` is high at a posedge, has priority over every other action:
  - pointers, `count` and `credit_out` go to 0;
  - both error flags clear;
  - FSM goes to IDLE;
  - `empty`=1, `full`=0.
- `mem` contents are not reset. `data_out`/`flit_id`/`dst_addr` are don't-care while `empty`.
- Reset mid-packet discards all stored flits. No credits are issued for discarded flits, and upstream credit counters are reset on the same `rst`.
- Write-to-visible latency is 1 cycle. Read-to-credit latency is 1 cycle.
- Sustained throughput is 1 flit/cycle with concurrent read and write at any occupancy 1..DEPTH−1.

## Structure
- Flit field positions (`FLIT_ID_MSB/LSB`, `DST_LSB/MSB`) and the flit-id codes live in the shared parameter definitions, also used by LBDR.
- The framing FSM state enum (`IDLE`, `IN_PKT`) is local to this block.
- One natural sub-module: `flit_framing_checker`, holding the FSM and `err_framing`. It takes `wr_fire` and `flit_id_in` as inputs.
- Storage, pointers and credit logic stay in `input_fifo`.

## Test plan
- **Reset then idle.** Hold `rst` 2 cycles, then run 5 cycles with no traffic → `empty`=1, `full`=0, `credit_out`=0, errors 0.
- **Single packet.** Write HEADER(dst=4'hA), PAYLOAD, TAIL on consecutive cycles, then assert `read_en` 3 cycles →
  - `flit_id` sequence is 001, 010, 100;
  - `dst_addr`=4'hA while the header is at the head;
  - 3 `credit_out` pulses, each one cycle after its read;
  - `empty` returns to 1; `err_framing`=0.
- **Fill and overflow.** Write 5 flits with no reads →
  - `full`=1 after the 4th write;
  - 5th flit dropped and `err_overflow`=1;
  - reading 4 flits returns flits 1–4 in order.
- **Full with simultaneous read and write.** At `count`=4, assert `read_en` and `valid_in` together → write dropped, `err_overflow`=1, `count`=3.
- **Wrap-around streaming.** Run 20 flits with read and write every cycle after the first write → output order matches input order, and `count` stays at 1.
- **Framing and mid-packet reset.** Send PAYLOAD first → `err_framing`=1. Then send HEADER, HEADER → flag stays 1. Assert `rst` mid-packet → flags clear, `empty`=1, no credits for the discarded flits.

Source files
------------

// File: rtl/input_fifo_pkg.sv
// Shared flit definitions for the input buffer and its framing checker.
// The field positions and flit-id codes are the same ones LBDR uses.
package input_fifo_pkg;

    // Flit field positions
    localparam int FLIT_ID_MSB = 31;
    localparam int FLIT_ID_LSB = 29;
    localparam int DST_MSB     = 3;
    localparam int DST_LSB     = 0;

    typedef logic [FLIT_ID_MSB-FLIT_ID_LSB:0] flit_id_t;

    // One-hot flit type codes
    localparam flit_id_t HEADER  = 3'b001;
    localparam flit_id_t PAYLOAD = 3'b010;
    localparam flit_id_t TAIL    = 3'b100;

    // Write-side packet framing state
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/input_fifo_if.sv
// Link-side and router-side signals of one input port buffer.
// master: link/allocator side (drives flits and read_en).
// slave:  the buffer itself.
interface input_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic [2:0]            flit_id;
    logic [3:0]            dst_addr;
    logic                  empty;
    logic                  full;
    logic                  credit_out;
    logic                  err_overflow;
    logic                  err_framing;

    modport master (
        output valid_in,
        output data_in,
        output read_en,
        input  data_out,
        input  flit_id,
        input  dst_addr,
        input  empty,
        input  full,
        input  credit_out,
        input  err_overflow,
        input  err_framing
    );

    modport slave (
        input  valid_in,
        input  data_in,
        input  read_en,
        output data_out,
        output flit_id,
        output dst_addr,
        output empty,
        output full,
        output credit_out,
        output err_overflow,
        output err_framing
    );
endinterface

// File: rtl/input_fifo_framing_checker.sv
// Write-side packet framing checker: tracks HEADER/PAYLOAD/TAIL ordering
// over accepted writes and raises a sticky flag on any illegal flit id.
// It only reports; it never blocks a write.
module flit_framing_checker
    import input_fifo_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_fire,
    input  flit_id_t flit_id_in,
    output logic     err_framing
);

    frame_state_e state;
    frame_state_e state_next;
    logic         err_set;

    // State register and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            err_framing <= 1'b0;
        end else begin
            state <= state_next;
            if (err_set) begin
                err_framing <= 1'b1;
            end
        end
    end

    // Next-state decode; an illegal flit leaves the state where it was
    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        if (wr_fire) begin
            case (state)
                IDLE: begin
                    if (flit_id_in == HEADER) begin
                        state_next = IN_PKT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                IN_PKT: begin
                    case (flit_id_in)
                        PAYLOAD: state_next = IN_PKT;
                        TAIL:    state_next = IDLE;
                        default: err_set    = 1'b1;
                    endcase
                end
                default: begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_fifo.sv
// Per-input-port flit buffer feeding LBDR. Circular buffer with a
// fall-through head view, one registered credit per drained flit, a sticky
// overflow flag and a write-side framing checker.
module input_fifo
    import input_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic              clk,
    input logic              rst,
    input_fifo_if.slave      bus
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;

    logic empty_int;
    logic full_int;
    logic wr_fire;
    logic rd_fire;
    logic credit_p1;
    logic err_overflow_q;
    logic err_framing_w;

    // Status decodes from the pre-cycle occupancy: a read in the same cycle
    // never frees a slot for a write while full.
    assign empty_int = (count == '0);
    assign full_int  = (count == FULL_COUNT);
    assign wr_fire   = bus.valid_in & ~full_int;
    assign rd_fire   = bus.read_en  & ~empty_int;

    // Flit storage, written on accepted writes; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Credit return one cycle after each drained flit; sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_p1      <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            credit_p1 <= rd_fire;
            if (bus.valid_in & full_int) begin
                err_overflow_q <= 1'b1;
            end
        end
    end

    flit_framing_checker u_framing (
        .clk         (clk),
        .rst         (rst),
        .wr_fire     (wr_fire),
        .flit_id_in  (bus.data_in[FLIT_ID_MSB:FLIT_ID_LSB]),
        .err_framing (err_framing_w)
    );

    // Head view is a plain read of the slot under rd_ptr: a write lands in
    // mem first and only shows up on data_out the following cycle.
    assign bus.data_out     = mem[rd_ptr];
    assign bus.flit_id      = bus.data_out[FLIT_ID_MSB:FLIT_ID_LSB];
    assign bus.dst_addr     = bus.data_out[DST_MSB:DST_LSB];
    assign bus.empty        = empty_int;
    assign bus.full         = full_int;
    assign bus.credit_out   = credit_p1;
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_framing  = err_framing_w;

endmodule
